// File: rtl/rotr_seq.sv
// rotr_seq: sequential right-circular rotator.
// One bit per clock in a single shift register, valid/ready on both sides.
module rotr_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic [AMT_W-1:0] count;
  logic             accept;
  logic             last;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = (count == AMT_W'(1));
  assign out_valid = (state_q == DONE);
  assign out_data  = shreg;
  assign busy      = (state_q != IDLE);

  // Next-state decode for the three-state control.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_amt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: load on accept, rotate right once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE) && accept: begin
          shreg <= in_data;
          count <= in_amt;
        end
        (state_q == SHIFT): begin
          shreg <= {shreg[0], shreg[WIDTH-1:1]};
          count <= count - AMT_W'(1);
        end
        default: begin
          shreg <= shreg;
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotr_seq.sv
// tb_rotr_seq: directed and round-trip checks for rotr_seq.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rotr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  rotr_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] d, input logic [2:0] n,
                       input logic [7:0] exp, input int stall,
                       input bit rnd_ready, input string nm);
    int k;
    logic bad;
    logic [7:0] held;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = n;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: in_ready=%b want 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_amt   = 3'($urandom);
    k = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && k < 20) begin
      if (busy !== 1'b1) bad = 1'b1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      k++;
    end
    out_ready = 1'b0;
    tests++;
    if (k !== int'(n)) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, n);
    end
    tests++;
    if (out_data !== exp) begin
      fails++;
      $display("FAIL %s data: got %h want %h", nm, out_data, exp);
    end
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      if (out_valid !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      if (out_data !== held) bad = 1'b1;
      tick();
    end
    if (out_valid !== 1'b1 || out_data !== held) bad = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || bad) begin
      fails++;
      $display("FAIL %s finish: out_valid=%b busy=%b bad=%b want 0 0 0",
               nm, out_valid, busy, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_amt = 3'd0;
    out_ready = 1'b0;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset ctl: out_valid=%b busy=%b want 0 0",
               out_valid, busy);
    end
    tests++;
    if (out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset data: got %h want 00", out_data);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset in_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL post-reset in_ready: got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    do_op(8'hA5, 3'd3, 8'hB4, 0, 1'b0, "basic");
    tests++;
    if (out_data !== 8'hB4 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic hold: data=%h in_ready=%b want b4 1",
               out_data, in_ready);
    end
  endtask

  task automatic test_amounts();
    do_op(8'h3C, 3'd0, 8'h3C, 0, 1'b0, "amt0");
    tick();
    do_op(8'h01, 3'd7, 8'h02, 0, 1'b0, "amt7");
    tick();
  endtask

  task automatic test_backpressure();
    logic bad;
    int k;
    do_op(8'h81, 3'd1, 8'hC0, 5, 1'b0, "bp");
    in_valid = 1'b1;
    in_data = 8'h55;
    in_amt = 3'd2;
    tick();
    in_data = 8'hFF;
    in_amt = 3'd2;
    bad = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      tick();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      tick();
    end
    tests++;
    if (out_data !== 8'h55 || bad) begin
      fails++;
      $display("FAIL block data: got %h bad=%b want 55 0", out_data, bad);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL block reopen: busy=%b in_ready=%b want 0 1",
               busy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tests++;
    if (out_data !== 8'hFF || k !== 2) begin
      fails++;
      $display("FAIL block second: data=%h lat=%0d want ff 2", out_data, k);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    in_valid = 1'b1;
    in_data = 8'hF0;
    in_amt = 3'd6;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      if (i == 0 && busy !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++;
    if (seen || out_data !== 8'h00) begin
      fails++;
      $display("FAIL rst-mid: seen=%b data=%h want 0 00", seen, out_data);
    end
    do_op(8'h12, 3'd4, 8'h21, 0, 1'b0, "after-rst");
    tick();
  endtask

  task automatic test_round_trip();
    logic [15:0] t;
    logic [7:0]  a;
    logic [7:0]  r;
    for (int ai = 0; ai < 256; ai++) begin
      for (int n = 0; n < 8; n++) begin
        a = 8'(ai);
        t = {a, a} << n;
        r = t[15:8];
        do_op(r, 3'(n), a, $urandom_range(0, 2), 1'b1, "roundtrip");
        if ($urandom_range(0, 1) == 1) tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_amounts();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rotr_seq.md
# rotr_seq

Sequential right-circular rotator. It is the inverse of the design's combinational left rotator: for any value A and amount n, `out_data = rotr(in_data, n)`, so `rotr(rotl(A,n),n) == A`. It takes operands over a valid/ready input handshake and rotates one bit position per clock in a single shift register. It returns the result over a valid/ready output handshake, trading latency for area in the tile.

## Interface
- WIDTH, 8, data width in bits; must be a power of two, ≥ 2
- AMT_W, $clog2(WIDTH) (3), rotation-amount width
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  block can accept operand; = (state == IDLE) && !rst
- in_data  input  WIDTH  value to rotate right
- in_amt  input  AMT_W  rotation amount, 0..WIDTH-1
- out_valid  output  1  result present; = (state == DONE)
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result; driven directly from the shift register
- busy  output  1  = (state != IDLE)

## Operation
- There are three states: IDLE, SHIFT and DONE. Internal registers are `shreg[WIDTH]` and `count[AMT_W]`.
- **Reset** (rst high at an edge):
  - state = IDLE, shreg = 0, count = 0.
  - Outputs: out_valid = 0, out_data = 0, busy = 0, in_ready = 0 while rst is high, in_ready = 1 in the first cycle after reset.
  - Reset overrides every other event in that cycle.
- **IDLE:**
  - On an edge with in_valid && in_ready: shreg ← in_data, count ← in_amt.
  - If in_amt == 0, next state is DONE; otherwise next state is SHIFT.
  - With in_valid low, nothing changes.
- **SHIFT:**
  - Each edge: shreg ← {shreg[0], shreg[WIDTH-1:1]} and count ← count − 1.
  - When count == 1 at the edge, next state is DONE.
  - in_valid is ignored (in_ready = 0).
- **DONE:**
  - out_valid = 1. out_data is held stable until the handshake completes.
  - On an edge with out_ready high, next state is IDLE.
  - No new operand is accepted in the same cycle as the output handshake; in_ready rises the following cycle.
- Only one operation is in flight at a time. in_data and in_amt are sampled only at the accept edge; later changes have no effect.
- out_data after the output handshake keeps the last result until the next accept or reset. It is meaningful only while out_valid = 1.
- out_ready asserted outside DONE is ignored.
- There is no out-of-range amount, because AMT_W covers exactly 0..WIDTH-1.

## Timing
- Let E0 be the accept edge and n = in_amt.
- out_valid rises immediately after edge E0+n:
  - n = 0 gives the result in the cycle after accept.
  - n = WIDTH-1 gives the result 7 cycles after accept (WIDTH = 8).
- Minimum operation period is n+2 cycles: accept, n shifts, output handshake, then IDLE for 1 cycle before the next accept.
- Backpressure (out_ready low) holds DONE for any number of cycles, with no data change.
- **Reset mid-operation** (SHIFT or DONE): the block returns to IDLE next cycle with out_valid = 0. The in-flight result is discarded and never presented.
- **Simultaneous in_valid and out_ready in DONE:** only the output handshake occurs; the operand must be held by the producer until in_ready is seen.

## Test plan
- **Reset values:** assert rst 2 cycles → out_valid = 0, out_data = 0x00, busy = 0, in_ready = 0; after release, in_ready = 1.
- **Basic rotate:** in_data = 0xA5, in_amt = 3, out_ready = 1 → out_valid rises 3 cycles after accept edge, out_data = 0xB4, pulse 1 cycle, then IDLE.
- **Zero and maximum amount:**
  - 0x3C, amt 0 → 0x3C one cycle after accept.
  - 0x01, amt 7 → 0x02 seven cycles after accept.
  - busy is high for exactly the operation duration.
- **Backpressure and input blocking:**
  - 0x81, amt 1, out_ready low 5 cycles → out_data = 0xC0, stable, out_valid held.
  - in_valid held high with 0xFF throughout is not accepted until in_ready returns.
- **Reset mid-SHIFT:** 0xF0, amt 6, rst at cycle 3 → next cycle IDLE, out_valid never asserted. A following 0x12, amt 4 → 0x21.
- **Exhaustive round trip:** for all A in 0..255 and n in 0..7, feed rotl(A,n) with amt n under random out_ready stalls and random in_valid gaps → every result equals A, and each latency equals n.
